dcache_direct: RTL and testbench

- Blocking, direct-mapped, write-back, write-allocate data cache between the core's word-wide load/store port and the line-wide memory model.
- Serves hits in one cycle.
- On a miss it writes back a dirty victim line if present, refills the line from memory, then completes the access.
- Its memory side drives the line memory's valid/write/addr/wr_data and consumes its ready/rd_data.

---
 rtl/dcache_direct.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_direct.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// Blocking direct-mapped, write-back, write-allocate data cache between a word-wide
// core load/store port and a line-wide memory with a valid/ready handshake.
module dcache_direct #(
    parameter int CACHE_SIZE = 4*1024*8,
    parameter int LINE_SIZE  = 32*8,
    parameter int ADDR_SIZE  = 32,
    parameter int WORD_SIZE  = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [ADDR_SIZE-1:0]   req_addr_i,
    input  logic [WORD_SIZE-1:0]   req_wdata_i,
    input  logic [WORD_SIZE/8-1:0] req_wstrb_i,
    output logic                   resp_valid_o,
    output logic [WORD_SIZE-1:0]   resp_rdata_o,
    output logic                   mem_valid_o,
    output logic                   mem_write_o,
    output logic [ADDR_SIZE-1:0]   mem_addr_o,
    output logic [LINE_SIZE-1:0]   mem_wr_data_o,
    input  logic [LINE_SIZE-1:0]   mem_rd_data_i,
    input  logic                   mem_ready_i
);

    localparam int NUM_LINES   = CACHE_SIZE / LINE_SIZE;
    localparam int OFFSET_BITS = $clog2(LINE_SIZE / 8);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int STRB_BITS   = WORD_SIZE / 8;
    localparam int BYTE_BITS   = $clog2(STRB_BITS);
    localparam int WSEL_BITS   = $clog2(LINE_SIZE / WORD_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WB_REQ    = 3'd1,
        ST_WB_WAIT   = 3'd2,
        ST_FILL_REQ  = 3'd3,
        ST_FILL_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    function automatic logic [WORD_SIZE-1:0] get_word(
        input logic [LINE_SIZE-1:0] line,
        input logic [WSEL_BITS-1:0] wsel
    );
        return line[int'(wsel)*WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic logic [LINE_SIZE-1:0] merge_line(
        input logic [LINE_SIZE-1:0] line,
        input logic [WSEL_BITS-1:0] wsel,
        input logic [WORD_SIZE-1:0] wdata,
        input logic [STRB_BITS-1:0] wstrb
    );
        logic [LINE_SIZE-1:0] res;
        res = line;
        for (int b = 0; b < STRB_BITS; b++) begin
            if (wstrb[b]) begin
                res[int'(wsel)*WORD_SIZE + b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                res[int'(wsel)*WORD_SIZE + b*8 +: 8] = line[int'(wsel)*WORD_SIZE + b*8 +: 8];
            end
        end
        return res;
    endfunction

    state_t                 state_r;
    logic [NUM_LINES-1:0]   valid_r;
    logic [NUM_LINES-1:0]   dirty_r;
    logic [TAG_BITS-1:0]    tag_mem_r  [NUM_LINES];
    logic [LINE_SIZE-1:0]   data_mem_r [NUM_LINES];

    logic [TAG_BITS-1:0]    req_tag_r;
    logic [INDEX_BITS-1:0]  req_idx_r;
    logic [WSEL_BITS-1:0]   req_wsel_r;
    logic [WORD_SIZE-1:0]   req_wdata_r;
    logic [STRB_BITS-1:0]   req_wstrb_r;
    logic                   req_write_r;

    logic                   req_ready_r;
    logic                   resp_valid_r;
    logic [WORD_SIZE-1:0]   resp_rdata_r;
    logic                   mem_valid_r;
    logic                   mem_write_r;
    logic [ADDR_SIZE-1:0]   mem_addr_r;
    logic [LINE_SIZE-1:0]   mem_wr_data_r;

    logic [TAG_BITS-1:0]    req_tag_s;
    logic [INDEX_BITS-1:0]  req_idx_s;
    logic [WSEL_BITS-1:0]   req_wsel_s;
    logic                   accept_s;
    logic                   hit_s;
    logic                   victim_dirty_s;
    logic                   mem_accept_s;
    logic                   unused_addr_s;

    assign req_tag_s      = req_addr_i[ADDR_SIZE-1 -: TAG_BITS];
    assign req_idx_s      = req_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign req_wsel_s     = req_addr_i[BYTE_BITS +: WSEL_BITS];
    assign unused_addr_s  = &{1'b0, req_addr_i[BYTE_BITS-1:0]};
    assign accept_s       = req_valid_i && req_ready_r;
    assign hit_s          = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s);
    assign victim_dirty_s = valid_r[req_idx_s] && dirty_r[req_idx_s];
    assign mem_accept_s   = mem_valid_r && mem_ready_i;

    assign req_ready_o   = req_ready_r;
    assign resp_valid_o  = resp_valid_r;
    assign resp_rdata_o  = resp_rdata_r;
    assign mem_valid_o   = mem_valid_r;
    assign mem_write_o   = mem_write_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_wr_data_o = mem_wr_data_r;

    // Cache controller: lookup, write-back, refill and all registered outputs.
    // mem_valid is only raised from a sampled-high mem_ready, which stays high until we request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            valid_r      <= '0;
            dirty_r      <= '0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            mem_valid_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_tag_r   <= req_tag_s;
                        req_idx_r   <= req_idx_s;
                        req_wsel_r  <= req_wsel_s;
                        req_wdata_r <= req_wdata_i;
                        req_wstrb_r <= req_wstrb_i;
                        req_write_r <= req_write_i;
                        if (hit_s) begin
                            resp_valid_r <= 1'b1;
                            req_ready_r  <= 1'b1;
                            if (req_write_i) begin
                                data_mem_r[req_idx_s] <= merge_line(data_mem_r[req_idx_s], req_wsel_s,
                                                                    req_wdata_i, req_wstrb_i);
                                dirty_r[req_idx_s]    <= 1'b1;
                                resp_rdata_r          <= '0;
                            end else begin
                                resp_rdata_r <= get_word(data_mem_r[req_idx_s], req_wsel_s);
                            end
                        end else if (victim_dirty_s) begin
                            state_r       <= ST_WB_REQ;
                            req_ready_r   <= 1'b0;
                            mem_valid_r   <= mem_ready_i;
                            mem_write_r   <= 1'b1;
                            mem_addr_r    <= {tag_mem_r[req_idx_s], req_idx_s, {OFFSET_BITS{1'b0}}};
                            mem_wr_data_r <= data_mem_r[req_idx_s];
                        end else begin
                            state_r     <= ST_FILL_REQ;
                            req_ready_r <= 1'b0;
                            mem_valid_r <= mem_ready_i;
                            mem_write_r <= 1'b0;
                            mem_addr_r  <= {req_tag_s, req_idx_s, {OFFSET_BITS{1'b0}}};
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_WB_REQ, ST_FILL_REQ: begin
                    if (mem_accept_s) begin
                        state_r     <= (state_r == ST_WB_REQ) ? ST_WB_WAIT : ST_FILL_WAIT;
                        mem_valid_r <= 1'b0;
                        mem_write_r <= 1'b0;
                    end else begin
                        mem_valid_r <= mem_ready_i;
                    end
                end
                ST_WB_WAIT: begin
                    if (mem_ready_i) begin
                        dirty_r[req_idx_r] <= 1'b0;
                        state_r            <= ST_FILL_REQ;
                        mem_valid_r        <= 1'b1;
                        mem_write_r        <= 1'b0;
                        mem_addr_r         <= {req_tag_r, req_idx_r, {OFFSET_BITS{1'b0}}};
                    end else begin
                        mem_valid_r <= 1'b0;
                    end
                end
                ST_FILL_WAIT: begin
                    if (mem_ready_i) begin
                        tag_mem_r[req_idx_r] <= req_tag_r;
                        valid_r[req_idx_r]   <= 1'b1;
                        dirty_r[req_idx_r]   <= req_write_r;
                        resp_valid_r         <= 1'b1;
                        state_r              <= ST_RESP;
                        if (req_write_r) begin
                            data_mem_r[req_idx_r] <= merge_line(mem_rd_data_i, req_wsel_r,
                                                                req_wdata_r, req_wstrb_r);
                            resp_rdata_r          <= '0;
                        end else begin
                            data_mem_r[req_idx_r] <= mem_rd_data_i;
                            resp_rdata_r          <= get_word(mem_rd_data_i, req_wsel_r);
                        end
                    end else begin
                        mem_valid_r <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                    mem_valid_r <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed vector table, multi-cycle corner
// sequences and random traffic against a flat word-memory reference model.
module tb_dcache_direct;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_valid;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wr_data;
    logic [255:0] mem_rd_data;
    logic         mem_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    dcache_direct dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .mem_valid_o  (mem_valid),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_wr_data_o(mem_wr_data),
        .mem_rd_data_i(mem_rd_data),
        .mem_ready_i  (mem_ready)
    );

    always #5 clk = ~clk;

    // Line memory covering byte addresses 0x0000-0x3FFF; ready drops for mem_delay cycles per transfer.
    logic [255:0] mem_lines [512];
    bit           mem_init_done = 1'b0;
    int           mem_delay = 5;
    int           busy_cnt = 0;
    int           rd_count = 0;
    int           wr_count = 0;
    int           viol_count = 0;
    int           oob_count = 0;
    logic [31:0]  last_wr_addr = '0;
    logic [255:0] last_wr_data = '0;

    assign mem_rd_data = mem_lines[mem_addr[13:5]];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 512; i++)
                for (int w = 0; w < 8; w++)
                    mem_lines[i][w*32 +: 32] <= $urandom;
            mem_lines[9'h080][31:0]  <= 32'h0000_0013;
            mem_lines[9'h080][63:32] <= 32'hCAFE_0001;
            mem_lines[9'h080][95:64] <= 32'h1122_3344;
            mem_lines[9'h100][95:64] <= 32'h5566_7788;
            mem_init_done <= 1'b1;
        end
        if (mem_valid && !mem_ready) viol_count <= viol_count + 1;
        if (mem_valid && mem_ready) begin
            if (mem_addr[4:0] != 5'd0 || mem_addr >= 32'h4000) oob_count <= oob_count + 1;
            busy_cnt  <= mem_delay;
            mem_ready <= 1'b0;
            if (mem_write) begin
                mem_lines[mem_addr[13:5]] <= mem_wr_data;
                wr_count     <= wr_count + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wr_data;
            end else begin
                rd_count <= rd_count + 1;
            end
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt  <= 0;
            mem_ready <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the response is seen.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd, output int lat,
                          output bit ok, output bit rdy_at_resp);
        int guard;
        ok = 1'b0; lat = 0; rd = '0; rdy_at_resp = 1'b0;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (resp_valid && guard < 200) begin
            ok = 1'b1;
            rd = resp_rdata;
            rdy_at_resp = req_ready;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(req_ready),  64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_mem_valid"},  64'(mem_valid),  64'd0);
        check({tag, "_mem_write"},  64'(mem_write),  64'd0);
        check({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] ref_words [4096];
    int          cl_line  [128];
    bit          cl_valid [128];
    bit          cl_dirty [128];

    task automatic model_reload();
        for (int w = 0; w < 4096; w++) ref_words[w] = mem_lines[w >> 3][(w % 8)*32 +: 32];
        for (int i = 0; i < 128; i++) begin
            cl_valid[i] = 1'b0;
            cl_dirty[i] = 1'b0;
            cl_line[i]  = -1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          ok;
        bit          rdy;
        int          rd0;
        int          wr0;

        vecs[0] = '{1'b0, 32'h1000, 32'h0,         4'b0000, 32'h0000_0013, 8,  1, 0};
        vecs[1] = '{1'b0, 32'h1004, 32'h0,         4'b0000, 32'hCAFE_0001, 1,  0, 0};
        vecs[2] = '{1'b1, 32'h1008, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1,  0, 0};
        vecs[3] = '{1'b0, 32'h1008, 32'h0,         4'b0000, 32'h11BB_33DD, 1,  0, 0};
        vecs[4] = '{1'b0, 32'h2008, 32'h0,         4'b0000, 32'h5566_7788, 15, 1, 1};
        vecs[5] = '{1'b0, 32'h1008, 32'h0,         4'b0000, 32'h11BB_33DD, 8,  1, 0};

        reset_i = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        @(negedge clk);

        // Directed table: cold miss, hit, partial store, dirty eviction, re-fetch.
        mem_delay = 5;
        for (int i = 0; i < 6; i++) begin
            rd0 = rd_count; wr0 = wr_count;
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat, ok, rdy);
            check($sformatf("vec%0d_seen", i),  64'(ok),  64'd1);
            check($sformatf("vec%0d_rdata", i), 64'(rd),  64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_lat", i),   64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_nrd", i),   64'(rd_count - rd0), 64'(vecs[i].exp_nrd));
            check($sformatf("vec%0d_nwr", i),   64'(wr_count - wr0), 64'(vecs[i].exp_nwr));
            check($sformatf("vec%0d_ready_at_resp", i), 64'(rdy), 64'(vecs[i].exp_lat == 1));
            @(negedge clk);
            check($sformatf("vec%0d_pulse_once", i), 64'(resp_valid), 64'd0);
        end
        check("wb_addr",  64'(last_wr_addr), 64'h1000);
        check("wb_word2", 64'(last_wr_data[95:64]), 64'h11BB_33DD);

        // Reset in the middle of a refill: no response, then a clean miss that waits for memory.
        mem_delay = 10;
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3000; req_wstrb = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        reset_i = 1'b0;
        @(negedge clk);
        rd0 = rd_count; wr0 = wr_count;
        do_req(1'b0, 32'h1000, 32'h0, 4'b0000, rd, lat, ok, rdy);
        check("midreset_seen",   64'(ok), 64'd1);
        check("midreset_rdata",  64'(rd), 64'h13);
        check("midreset_waited", 64'(lat > mem_delay + 3), 64'd1);
        check("midreset_nrd",    64'(rd_count - rd0), 64'd1);
        check("midreset_nwr",    64'(wr_count - wr0), 64'd0);

        // Back-to-back hits on the line just filled: one response per cycle, no memory traffic.
        begin
            logic [31:0] b2b_addr [3];
            logic [31:0] b2b_exp  [3];
            b2b_addr[0] = 32'h1000; b2b_exp[0] = 32'h0000_0013;
            b2b_addr[1] = 32'h1004; b2b_exp[1] = 32'hCAFE_0001;
            b2b_addr[2] = 32'h1008; b2b_exp[2] = 32'h11BB_33DD;
            @(negedge clk);
            while (!req_ready) @(negedge clk);
            rd0 = rd_count; wr0 = wr_count;
            for (int k = 0; k < 3; k++) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = b2b_addr[k]; req_wstrb = '0;
                @(posedge clk);
                @(negedge clk);
                check($sformatf("b2b%0d_valid", k), 64'(resp_valid), 64'd1);
                check($sformatf("b2b%0d_rdata", k), 64'(resp_rdata), 64'(b2b_exp[k]));
                check($sformatf("b2b%0d_ready", k), 64'(req_ready),  64'd1);
            end
            req_valid = 1'b0;
            @(negedge clk);
            check("b2b_pulse_end", 64'(resp_valid), 64'd0);
            check("b2b_no_mem",    64'((rd_count - rd0) + (wr_count - wr0)), 64'd0);
        end

        // Random traffic over a few conflicting lines against the flat-memory model.
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        model_reload();
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            bit          wr;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [3:0]  ws;
            logic [31:0] exp_rd;
            int          ix;
            int          ln;
            int          exp_lat;
            int          exp_nrd;
            int          exp_nwr;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 5)
                 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            wd   = $urandom;
            ws   = 4'($urandom_range(0, 15));
            mem_delay = $urandom_range(1, 4);
            ix = int'(addr[11:5]);
            ln = int'(addr >> 5);
            if (cl_valid[ix] && cl_line[ix] == ln) begin
                exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
            end else if (cl_valid[ix] && cl_dirty[ix]) begin
                exp_lat = 2*mem_delay + 5; exp_nrd = 1; exp_nwr = 1;
            end else begin
                exp_lat = mem_delay + 3; exp_nrd = 1; exp_nwr = 0;
            end
            if (exp_lat != 1) begin
                cl_line[ix] = ln; cl_valid[ix] = 1'b1; cl_dirty[ix] = 1'b0;
            end
            exp_rd = wr ? 32'h0 : ref_words[addr >> 2];
            if (wr) begin
                cl_dirty[ix] = 1'b1;
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_words[addr >> 2][b*8 +: 8] = wd[b*8 +: 8];
            end
            rd0 = rd_count; wr0 = wr_count;
            do_req(wr, addr, wd, ws, rd, lat, ok, rdy);
            check($sformatf("rnd%0d_seen", n),  64'(ok),  64'd1);
            check($sformatf("rnd%0d_rdata", n), 64'(rd),  64'(exp_rd));
            check($sformatf("rnd%0d_lat", n),   64'(lat), 64'(exp_lat));
            check($sformatf("rnd%0d_nrd", n),   64'(rd_count - rd0), 64'(exp_nrd));
            check($sformatf("rnd%0d_nwr", n),   64'(wr_count - wr0), 64'(exp_nwr));
        end

        @(negedge clk);
        check("mem_valid_while_busy", 64'(viol_count), 64'd0);
        check("mem_addr_alignment",   64'(oob_count),  64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
